// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output unload path.
// Holds the frame geometry, sequencer states and the address bit-reverse helper.
package fft_pkg;

    localparam int FFT_LOG2N       = 11;
    localparam int FFT_N           = 2 ** FFT_LOG2N;
    localparam int FFT_MUX_LATENCY = 3;

    typedef logic [FFT_LOG2N-1:0] fft_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } unload_state_t;

    function automatic fft_sel_t bitrev(input fft_sel_t a);
        fft_sel_t r;
        for (int i = 0; i < FFT_LOG2N; i++) begin
            r[i] = a[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_unload_if.sv
// Valid/ready output stream of the FFT unload sequencer.
// master drives valid/data/last, slave drives ready.
interface fft_bitrev_unload_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fft_unload_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// Buffers {last, data} words returned by the mux pipeline.
module fft_unload_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (count <= CW'(DEPTH));
    end

endmodule

// File: rtl/fft_bitrev_unload.sv
// Unload sequencer: drives the 2048x1 mux select and streams the frame out.
// Define FFT_UNLOAD_BITREV_EN for bit-reversed addressing (default natural).
module fft_bitrev_unload
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LOG2N       = FFT_LOG2N,
    parameter int MUX_LATENCY = FFT_MUX_LATENCY,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [LOG2N-1:0]      sel_o,
    input  logic [DATA_WIDTH-1:0] mux_data_i,
    fft_bitrev_unload_if.master   m
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    if (FIFO_DEPTH < MUX_LATENCY + 2) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least MUX_LATENCY+2");
    end

    unload_state_t          state;
    logic [LOG2N-1:0]       cnt;
    logic [MUX_LATENCY-1:0] tag_v;
    logic [MUX_LATENCY-1:0] tag_l;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          fifo_count;
    logic [CW:0]            occ_next;
    logic                   fifo_empty;
    logic [DATA_WIDTH:0]    fifo_out;
    logic                   issue;
    logic                   pop;

`ifdef FFT_UNLOAD_BITREV_EN
    if (LOG2N != FFT_LOG2N) begin : g_rev_chk
        $error("bit-reverse addressing needs LOG2N == FFT_LOG2N");
    end
    assign sel_o = bitrev(cnt);
`else
    assign sel_o = cnt;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUX_LATENCY; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    // Registered occupancy only: a pop this cycle does not free a credit yet.
    assign occ_next = {1'b0, inflight} + {1'b0, fifo_count} + (CW+1)'(1);
    assign issue    = (state == ISSUE) && (occ_next <= (CW+1)'(FIFO_DEPTH));

    assign m.m_valid = !fifo_empty;
    assign pop       = m.m_valid && m.m_ready;
    assign m.m_data  = m.m_valid ? fifo_out[DATA_WIDTH-1:0] : '0;
    assign m.m_last  = m.m_valid && fifo_out[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        if (cnt == LAST_IDX) state <= DRAIN;
                        else                 cnt   <= cnt + LOG2N'(1);
                    end
                end
                DRAIN: begin
                    if (pop && m.m_last && inflight == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v <= (tag_v << 1) | MUX_LATENCY'(issue);
            tag_l <= (tag_l << 1) | MUX_LATENCY'(issue && cnt == LAST_IDX);
        end
    end

    fft_unload_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_v[MUX_LATENCY-1]),
        .push_data ({tag_l[MUX_LATENCY-1], mux_data_i}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fft_bitrev_unload.sv
// Directed bench for fft_bitrev_unload with a 3-cycle mux model.
// Covers reset, full rate, backpressure, stall, restart and mid-frame reset.
module tb_fft_bitrev_unload;
    import fft_pkg::*;

    localparam int N = FFT_N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [10:0] sel;
    logic [7:0]  mux_data;
    logic [7:0]  mp [3];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          s;
    int          s2;
    int          dummy;

    fft_bitrev_unload_if #(.DATA_WIDTH(8)) ifc ();

    fft_bitrev_unload dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sel_o      (sel),
        .mux_data_i (mux_data),
        .m          (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: data_i[k] = k[7:0], three register stages, no reset.
    always @(posedge clk) begin
        mp[0] <= sel[7:0];
        mp[1] <= mp[0];
        mp[2] <= mp[1];
    end
    assign mux_data = mp[2];

    function automatic logic [10:0] addr_of(input int j);
        logic [10:0] a;
        logic [10:0] r;
        a = j[10:0];
`ifdef FFT_UNLOAD_BITREV_EN
        for (int i = 0; i < 11; i++) r[10-i] = a[i];
`else
        r = a;
`endif
        return r;
    endfunction

    function automatic logic [7:0] exp_word(input int j);
        logic [10:0] r;
        r = addr_of(j);
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic start_frame(output int s_out);
        @(negedge clk);
        start = 1'b1;
        s_out = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", busy, 1);
    endtask

    task automatic recv(input int low_pct, input int s_in, input bit chk_lat,
                        input int pulse_at, input int abort_at,
                        input bit restart, output int s_next);
        int idx = 0;
        int fv = -1;
        int fc = 0;
        int lc = 0;
        int n = 0;
        bit stalled = 1'b0;
        bit rdy;
        logic [7:0] hd = '0;
        logic hl = 1'b0;
        s_next = 0;
        while (idx < N && n < 20000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (stalled) begin
                check("hold_valid", ifc.m_valid, 1);
                check("hold_data", ifc.m_data, hd);
                check("hold_last", ifc.m_last, hl);
            end
            rdy = ($urandom_range(0, 99) >= low_pct);
            ifc.m_ready = rdy;
            if (ifc.m_valid && fv < 0) fv = cyc;
            stalled = ifc.m_valid && !rdy;
            hd = ifc.m_data;
            hl = ifc.m_last;
            if (ifc.m_valid && rdy) begin
                check("data", ifc.m_data, exp_word(idx));
                check("last", ifc.m_last, idx == N - 1);
                if (idx == 0) fc = cyc;
                lc = cyc;
                idx++;
                if (idx == pulse_at) start = 1'b1;
                if (idx == abort_at + 1) return;
            end
        end
        check("frame_words", idx, N);
        if (idx != N) return;
        if (chk_lat) check("first_valid", fv - s_in, 5);
        if (chk_lat && low_pct == 0) check("span", lc - fc, N - 1);
        @(negedge clk);
        check("done", done, 1);
        check("busy_off", busy, 0);
        if (restart) begin
            start = 1'b1;
            s_next = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("busy_next", busy, restart);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ifc.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", ifc.m_valid, 0);
        check("rst_last", ifc.m_last, 0);
        check("rst_data", ifc.m_data, 0);
        check("rst_sel", sel, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", ifc.m_valid, 0);
        check("idle_done", done, 0);

        // Full rate, restart in the done cycle, then backpressure frame.
        ifc.m_ready = 1'b1;
        start_frame(s);
        recv(0, s, 1'b1, -1, -1, 1'b1, s2);
        recv(30, s2, 1'b1, 500, -1, 1'b0, dummy);

        // Consumer stalled: issue stops after FIFO_DEPTH credits.
        ifc.m_ready = 1'b0;
        start_frame(s);
        repeat (10) @(negedge clk);
        check("stall_sel", sel, addr_of(8));
        check("stall_valid", ifc.m_valid, 1);
        check("stall_head", ifc.m_data, exp_word(0));
        repeat (20) @(negedge clk);
        check("stall_sel_hold", sel, addr_of(8));
        recv(0, s, 1'b0, -1, -1, 1'b0, dummy);

        // Reset after word 100 is accepted.
        ifc.m_ready = 1'b1;
        start_frame(s);
        recv(0, s, 1'b1, -1, 100, 1'b0, dummy);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", ifc.m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_last", ifc.m_last, 0);
        check("mid_rst_data", ifc.m_data, 0);
        check("mid_rst_sel", sel, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stale_valid", ifc.m_valid, 0);
        end
        start_frame(s);
        recv(0, s, 1'b1, -1, -1, 1'b0, dummy);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
